mod_counter_ctrl: RTL

Command-driven controller that sequences a modulo-M counter: it loads the modulus and period count, starts, pauses, resumes and stops counting, and reports wrap and completion events. It sits between a register or CPU-style command source and the counter datapath. The counter datapath is instantiated inside as a sub-module. Downstream logic consumes `count`, `wrap` and `done` as a programmable timebase.

---
 rtl/mod_counter_pkg.sv | 26 ++
 rtl/modn_counter.sv | 46 ++++
 rtl/mod_counter_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo-M counter controller and its datapath.
package mod_counter_pkg;

    localparam int CW_DEF = 4;
    localparam int RW_DEF = 8;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_PAUSE  = 2'd2,
        OP_RESUME = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Terminal count of a modulo-m counter; m = 0 wraps naturally to all ones (2^w - 1).
    function automatic logic [15:0] term_value(input logic [15:0] m);
        return m - 16'd1;
    endfunction

endpackage

// File: rtl/modn_counter.sv
// Modulo-mod counter datapath with registered wrap pulse; mod = 0 counts modulo 2^CW.
module modn_counter
    import mod_counter_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] mod,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_q;
    logic          wrap_q;
    logic [CW-1:0] term_s;

    assign term_s = mod - CW'(1);

    // Count register and wrap pulse; clear has priority over enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= {CW{1'b0}};
            wrap_q  <= 1'b0;
        end else if (clr) begin
            count_q <= {CW{1'b0}};
            wrap_q  <= 1'b0;
        end else if (en) begin
            if (count_q == term_s) begin
                count_q <= {CW{1'b0}};
                wrap_q  <= 1'b1;
            end else begin
                count_q <= count_q + CW'(1);
                wrap_q  <= 1'b0;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/mod_counter_ctrl.sv
// Command-driven controller sequencing a modulo-M counter over a programmed number of periods.
module mod_counter_ctrl
    import mod_counter_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_mod,
    input  logic [RW-1:0] cmd_reps,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          done,
    output logic          busy,
    output logic          err
);

    state_e        state_q, state_d;
    logic [CW-1:0] mod_q;
    logic [RW-1:0] reps_q;
    logic [RW-1:0] per_q;
    logic          ready_q, busy_q, done_q, err_q;
    logic          done_d, err_d;
    logic          acc_s, en_s, clr_s, load_s, term_s, last_s;
    cmd_op_e       op_s;
    logic [CW-1:0] count_s;

    assign acc_s  = cmd_valid && ready_q;
    assign op_s   = cmd_op_e'(cmd_op);
    assign term_s = (count_s == mod_q - CW'(1));
    assign last_s = (reps_q != {RW{1'b0}}) && (per_q == reps_q - RW'(1));

    // Command decode and next-state logic; STOP/START/PAUSE override the counting step.
    always_comb begin
        state_d = state_q;
        en_s    = 1'b0;
        clr_s   = 1'b0;
        load_s  = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_s && op_s == OP_START) begin
                    load_s  = 1'b1;
                    clr_s   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    err_d = acc_s;
                end
            end
            ST_RUN: begin
                if (acc_s && op_s == OP_STOP) begin
                    clr_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (acc_s && op_s == OP_START) begin
                    load_s  = 1'b1;
                    clr_s   = 1'b1;
                    state_d = ST_RUN;
                end else if (acc_s && op_s == OP_PAUSE) begin
                    state_d = ST_PAUSE;
                end else begin
                    en_s  = 1'b1;
                    err_d = acc_s;
                    if (term_s && last_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PAUSE: begin
                if (acc_s && op_s == OP_STOP) begin
                    clr_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (acc_s && op_s == OP_START) begin
                    load_s  = 1'b1;
                    clr_s   = 1'b1;
                    state_d = ST_RUN;
                end else if (acc_s && op_s == OP_RESUME) begin
                    state_d = ST_RUN;
                end else begin
                    err_d = acc_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                clr_s   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, programmed fields, period counter and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mod_q   <= {CW{1'b0}};
            reps_q  <= {RW{1'b0}};
            per_q   <= {RW{1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_s) begin
                mod_q  <= cmd_mod;
                reps_q <= cmd_reps;
                per_q  <= {RW{1'b0}};
            end else if (en_s && term_s && per_q != {RW{1'b1}}) begin
                per_q <= per_q + RW'(1);
            end else begin
                per_q <= per_q;
            end
            ready_q <= (state_d != ST_DONE);
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    modn_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en_s),
        .clr   (clr_s),
        .mod   (mod_q),
        .count (count_s),
        .wrap  (wrap)
    );

    assign count     = count_s;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
